uart_rx: RTL and testbench

- UART receiver: deserializes the asynchronous serial line uart_rxd into 8-bit bytes.
- Frame format: 1 start bit, 8 data bits LSB first, 1 or 2 stop bits, no parity.
- Companion of uart_tx. Shares the cfg_div / cfg_nstop programming model and presents bytes on a valid/ready interface with a one-entry holding register.
- Reports framing errors and overflow as single-cycle pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync_ff.sv | 26 ++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and receiver state encoding.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP1,
    STOP2
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// N-stage flop synchronizer for a single asynchronous bit, resets to RST_VAL.
module sync_ff #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift the input through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbour.
    if (rst) begin
      sync_q <= {N{RST_VAL}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1/8N2 deserializer with a one-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_rxen,
  input  logic              cfg_nstop,
  input  logic              uart_rxd,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_overflow
);

  rx_state_t         state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              rxd_s;
  logic              rxd_dly_q;

  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              frame_err_q;
  logic              overflow_q, overflow_d;

  logic [DIV_W-1:0]  half_div;
  logic [DIV_W-1:0]  last_cnt;
  logic              start_edge;
  logic              stop_sample;
  logic              final_stop;
  logic              deliver;
  logic              frame_bad;

  sync_ff #(
    .N       (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (uart_rxd),
    .q_o (rxd_s)
  );

  // One-cycle delayed copy of the synchronized line for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_dly_q <= 1'b1;
    end else begin
      rxd_dly_q <= rxd_s;
    end
  end

  assign half_div    = cfg_div >> 1;
  assign last_cnt    = cfg_div - DIV_W'(1);
  assign start_edge  = rxd_dly_q & ~rxd_s;
  assign stop_sample = cfg_rxen && ((state_q == STOP1) || (state_q == STOP2)) && (cnt_q == last_cnt);
  assign final_stop  = (state_q == STOP2) || !cfg_nstop;
  assign deliver     = stop_sample && rxd_s && final_stop;
  assign frame_bad   = stop_sample && !rxd_s;

  // Frame FSM: baud counting, mid-bit sampling and data assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else if (!cfg_rxen) begin
      // Disabling aborts any partial frame without raising a flag.
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // An edge is required, so a held-low line (break) cannot retrigger.
          if (start_edge) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == half_div) begin
            cnt_q <= '0;
            if (rxd_s) begin
              state_q <= IDLE;  // glitch shorter than half a bit: false start
            end else begin
              bit_idx_q <= '0;
              state_q   <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == last_cnt) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rxd_s;
            if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
              state_q <= STOP1;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        STOP1: begin
          // Leaving at mid-stop lets a start edge in the second half be caught.
          if (cnt_q == last_cnt) begin
            cnt_q   <= '0;
            state_q <= (rxd_s && cfg_nstop) ? STOP2 : IDLE;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        STOP2: begin
          if (cnt_q == last_cnt) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Holding register next state: consume, load, or keep.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (deliver && (!rx_valid_q || rx_ready)) begin
      rx_valid_d = 1'b1;
      rx_data_d  = shift_q;
    end
  end

  assign overflow_d = deliver && rx_valid_q && !rx_ready;

  // Registered consumer-side outputs and single-cycle error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_bad;
      overflow_q  <= overflow_d;
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial driver, event-timed reference model, per-cycle compare.
module tb_uart_rx;

  localparam int SYNC  = 2;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_rxen;
  logic             cfg_nstop;
  logic             uart_rxd;
  logic             rx_ready;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_frame_err;
  logic             rx_overflow;

  always #5 clk = ~clk;

  uart_rx #(
    .SYNC_STAGES (SYNC),
    .DIV_W       (DIV_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_div      (cfg_div),
    .cfg_rxen     (cfg_rxen),
    .cfg_nstop    (cfg_nstop),
    .uart_rxd     (uart_rxd),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overflow  (rx_overflow)
  );

  // Expected outcome of one frame: at clock edge 'at' either a byte or a framing error appears.
  typedef struct {
    int unsigned at;
    bit          err;
    logic [7:0]  data;
  } ev_t;

  ev_t         evq[$];
  logic [7:0]  rcv[$];
  int unsigned cyc       = 0;
  int unsigned last_rise = 0;
  int          ferr_cnt  = 0;
  int          ovf_cnt   = 0;
  logic        prev_v    = 1'b0;
  bit          run       = 1'b0;
  bit          rand_done = 1'b0;
  int          n_cmp     = 0;
  int          n_bad     = 0;

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_ovf   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Reference model: holding register driven by the timed frame outcomes.
  always @(posedge clk) begin : model
    logic        v;
    logic [7:0]  d;
    logic        fe;
    logic        ov;
    int unsigned c;
    c = cyc + 1;
    cyc <= c;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ferr  <= 1'b0;
      m_ovf   <= 1'b0;
      evq.delete();
    end else begin
      v  = m_valid;
      d  = m_data;
      fe = 1'b0;
      ov = 1'b0;
      if (m_valid && rx_ready) v = 1'b0;
      if (evq.size() > 0 && evq[0].at == c) begin
        if (evq[0].err) fe = 1'b1;
        else if (m_valid && !rx_ready) ov = 1'b1;
        else begin
          v = 1'b1;
          d = evq[0].data;
        end
        void'(evq.pop_front());
      end
      m_valid <= v;
      m_data  <= d;
      m_ferr  <= fe;
      m_ovf   <= ov;
    end
  end

  // Consumer log: bytes handed over on valid && ready.
  always @(posedge clk) begin
    if (run && !rst && rx_valid && rx_ready) rcv.push_back(rx_data);
  end

  // Per-cycle compare of all outputs against the model, plus pulse/rise bookkeeping.
  always @(negedge clk) begin
    if (run && !rst) begin
      check($sformatf("cyc%0d {valid,data,ferr,ovf}", cyc),
            {21'd0, rx_valid, rx_data, rx_frame_err, rx_overflow},
            {21'd0, m_valid, m_data, m_ferr, m_ovf});
      if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
      if (rx_overflow) ovf_cnt <= ovf_cnt + 1;
      if (rx_valid && !prev_v) last_rise <= cyc;
    end
    prev_v <= rx_valid;
  end

  task automatic drive_bit(input logic b);
    uart_rxd = b;
    repeat (cfg_div) @(negedge clk);
  endtask

  // Drive one frame; if exp_ev, record when and what the receiver must report.
  task automatic send(input logic [7:0] d, input bit two_stop, input bit stop_ok,
                      input bit exp_ev, output int unsigned s);
    int unsigned k;
    cfg_nstop = two_stop;
    s = cyc;
    k = (two_stop && stop_ok) ? 2 : 1;
    if (exp_ev)
      evq.push_back('{at: s + SYNC + 1 + cfg_div / 2 + (8 + k) * cfg_div + 1,
                      err: !stop_ok, data: d});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
    if (two_stop) drive_bit(1'b1);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  int unsigned s0, s1;

  initial begin
    uart_rxd  = 1'b1;
    cfg_div   = 16'd869;
    cfg_rxen  = 1'b1;
    cfg_nstop = 1'b0;
    rx_ready  = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_ovf", rx_overflow, 0);
    rst = 1'b0;
    run = 1'b1;
    idle(5);

    // Single byte at 115200 baud: latency from drive = sync + edge flop + 434 + 9*869 + 1.
    send(8'hA5, 1'b0, 1'b1, 1'b1, s0);
    idle(4);
    check("single_latency", last_rise - s0, 8259);
    check("single_count", rcv.size(), 1);
    if (rcv.size() > 0) check("single_data", rcv.pop_front(), 8'hA5);

    // Glitch shorter than half a bit, then a real byte.
    uart_rxd = 1'b0;
    repeat (200) @(negedge clk);
    idle(1000);
    check("glitch_count", rcv.size(), 0);
    send(8'h81, 1'b0, 1'b1, 1'b1, s0);
    idle(20);
    check("after_glitch_count", rcv.size(), 1);
    if (rcv.size() > 0) check("after_glitch_data", rcv.pop_front(), 8'h81);
    check("glitch_ferr", ferr_cnt, 0);

    // Back-to-back with two stop bits at a short divisor.
    cfg_div = 16'd37;
    idle(5);
    send(8'h3C, 1'b1, 1'b1, 1'b1, s0);
    send(8'hC3, 1'b1, 1'b1, 1'b1, s0);
    idle(20);
    check("b2b_count", rcv.size(), 2);
    if (rcv.size() > 1) begin
      check("b2b_first", rcv.pop_front(), 8'h3C);
      check("b2b_second", rcv.pop_front(), 8'hC3);
    end

    // Framing error, then a good byte.
    send(8'h55, 1'b0, 1'b0, 1'b1, s0);
    idle(5);
    send(8'h12, 1'b0, 1'b1, 1'b1, s0);
    idle(20);
    check("ferr_pulses", ferr_cnt, 1);
    check("ferr_next_count", rcv.size(), 1);
    if (rcv.size() > 0) check("ferr_next_data", rcv.pop_front(), 8'h12);

    // Overflow: consumer stalled for two bytes.
    rx_ready = 1'b0;
    send(8'h11, 1'b0, 1'b1, 1'b1, s0);
    send(8'h22, 1'b0, 1'b1, 1'b1, s0);
    idle(10);
    check("ovf_valid", rx_valid, 1);
    check("ovf_data", rx_data, 8'h11);
    check("ovf_pulses", ovf_cnt, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    check("ovf_drain_valid", rx_valid, 0);
    check("ovf_drain_data", rcv.size() > 0 ? rcv.pop_front() : 8'h00, 8'h11);

    // Async reset mid-frame with a full holding register.
    send(8'h5A, 1'b0, 1'b1, 1'b1, s0);
    idle(10);
    check("pre_rst_valid", rx_valid, 1);
    fork
      send(8'h66, 1'b0, 1'b1, 1'b0, s0);
      begin
        repeat (150) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_ferr", rx_frame_err, 0);
        check("mid_rst_ovf", rx_overflow, 0);
      end
    join
    @(negedge clk);
    #1 rst = 1'b0;
    idle(5);
    rx_ready = 1'b1;
    send(8'h7E, 1'b0, 1'b1, 1'b1, s0);
    idle(20);
    check("post_rst_count", rcv.size(), 1);
    if (rcv.size() > 0) check("post_rst_data", rcv.pop_front(), 8'h7E);

    // Receiver disabled mid-frame: no delivery, holding register retained.
    rx_ready = 1'b0;
    send(8'h24, 1'b0, 1'b1, 1'b1, s0);
    idle(5);
    fork
      send(8'h99, 1'b0, 1'b1, 1'b0, s0);
      begin
        repeat (200) @(negedge clk);
        cfg_rxen = 1'b0;
      end
    join
    cfg_rxen = 1'b1;
    idle(10);
    check("rxen_valid", rx_valid, 1);
    check("rxen_data", rx_data, 8'h24);
    check("rxen_ovf", ovf_cnt, 1);
    rx_ready = 1'b1;
    idle(3);
    check("rxen_count", rcv.size(), 1);
    if (rcv.size() > 0) check("rxen_drain", rcv.pop_front(), 8'h24);

    // Randomized frames, divisors, stop counts, stop errors and consumer stalls.
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          bit ok;
          ok = ($urandom_range(0, 7) != 0);
          cfg_div = 16'($urandom_range(4, 48));
          send(8'($urandom), 1'($urandom), ok, 1'b1, s1);
          uart_rxd = 1'b1;
          repeat (ok ? $urandom_range(0, 3) : $urandom_range(2, 5)) @(negedge clk);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rx_ready = 1'b1;
    idle(60);
    check("events_drained", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
